// File: rtl/mmio_cmd_master.sv
// Byte-stream command interpreter that masters the 8-bit peripheral bus.
// Host sends W/R/B commands; responses (ACK, read data, ERR) return on the tx stream.
module mmio_cmd_master #(
   parameter logic [7:0] ACK_BYTE = 8'h2B,
   parameter logic [7:0] ERR_BYTE = 8'h3F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] bus_addr,
   output logic       bus_we,
   output logic [7:0] bus_wdata,
   input  logic [7:0] bus_rdata,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_ADDR = 3'd1,
      GET_DATA = 3'd2,
      GET_CNT  = 3'd3,
      WRITE    = 3'd4,
      READ     = 3'd5,
      SEND     = 3'd6
   } state_t;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] OP_BURST = 8'h42;

   state_t     state;
   logic [7:0] opcode;
   logic [7:0] remaining;
   logic       take;

   // Byte intake is only open in the states that collect command fields.
   assign rx_ready = !rst && ((state == IDLE) || (state == GET_ADDR) ||
                              (state == GET_DATA) || (state == GET_CNT));
   assign take     = rx_valid && rx_ready;
   assign busy     = (state != IDLE);

   // Command sequencer: field capture, bus cycle, and response hand-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         opcode    <= 8'h00;
         remaining <= 8'h00;
         bus_addr  <= 8'h00;
         bus_wdata <= 8'h00;
         bus_we    <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= 8'h00;
      end else begin
         bus_we <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  opcode <= rx_data;
                  if ((rx_data == OP_WRITE) || (rx_data == OP_READ) || (rx_data == OP_BURST)) begin
                     state <= GET_ADDR;
                  end else begin
                     tx_data  <= ERR_BYTE;
                     tx_valid <= 1'b1;
                     state    <= SEND;
                  end
               end
            end
            GET_ADDR: begin
               if (take) begin
                  bus_addr <= rx_data;
                  if (opcode == OP_WRITE) begin
                     state <= GET_DATA;
                  end else if (opcode == OP_BURST) begin
                     state <= GET_CNT;
                  end else begin
                     state <= READ;
                  end
               end
            end
            GET_DATA: begin
               if (take) begin
                  bus_wdata <= rx_data;
                  bus_we    <= 1'b1;
                  state     <= WRITE;
               end
            end
            GET_CNT: begin
               if (take) begin
                  remaining <= rx_data;
                  if (rx_data == 8'h00) begin
                     tx_data  <= ERR_BYTE;
                     tx_valid <= 1'b1;
                     state    <= SEND;
                  end else begin
                     state <= READ;
                  end
               end
            end
            WRITE: begin
               tx_data  <= ACK_BYTE;
               tx_valid <= 1'b1;
               state    <= SEND;
            end
            READ: begin
               tx_data  <= bus_rdata;
               tx_valid <= 1'b1;
               state    <= SEND;
            end
            SEND: begin
               // A burst re-enters READ at the next address after each accepted byte.
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  if ((opcode == OP_BURST) && (remaining > 8'h01)) begin
                     remaining <= remaining - 8'h01;
                     bus_addr  <= bus_addr + 8'h01;
                     state     <= READ;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               tx_valid <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_cmd_master.sv
// Self-checking bench for mmio_cmd_master: command-level model predicts bus writes
// and tx bytes; a register-file responder serves the bus.
module tb_mmio_cmd_master;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] bus_addr;
   logic       bus_we;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata;
   logic       busy;

   mmio_cmd_master dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .busy(busy)
   );

   int errors;
   int checks;
   int cyc;
   int tcnt;
   int rx_edge;
   int we_cyc;
   int tx_edge;
   bit stall_mode;
   bit rx_pend;
   bit stalled;
   logic [7:0] held;

   logic [7:0] mem [256];
   logic [7:0] model_mem [256];
   logic [7:0] rxq [$];
   logic [7:0] exp_tx [$];
   logic [7:0] exp_txa [$];
   bit         exp_txc [$];
   logic [7:0] exp_wa [$];
   logic [7:0] exp_wd [$];
   logic [7:0] tx_log [$];

   always #5 clk = ~clk;

   // Peripheral responder: combinational read, write on strobe.
   assign bus_rdata = mem[bus_addr];
   always @(posedge clk) begin
      cyc++;
      if (bus_we) mem[bus_addr] <= bus_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic push_tx(input logic [7:0] d, input logic [7:0] a, input bit c);
      exp_tx.push_back(d);
      exp_txa.push_back(a);
      exp_txc.push_back(c);
   endtask

   // Command-level model: queue the bytes and predict every effect of the command.
   task automatic cmd(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] a;
      rxq.push_back(b0);
      if (n > 1) rxq.push_back(b1);
      if (n > 2) rxq.push_back(b2);
      case (b0)
         8'h57: begin
            model_mem[b1] = b2;
            exp_wa.push_back(b1);
            exp_wd.push_back(b2);
            push_tx(8'h2B, 8'h00, 1'b0);
         end
         8'h52: push_tx(model_mem[b1], b1, 1'b1);
         8'h42: begin
            if (b2 == 8'h00) push_tx(8'h3F, 8'h00, 1'b0);
            for (int i = 0; i < int'(b2); i++) begin
               a = b1 + 8'(i);
               push_tx(model_mem[a], a, 1'b1);
            end
         end
         default: push_tx(8'h3F, 8'h00, 1'b0);
      endcase
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!(rxq.size() == 0 && exp_tx.size() == 0 && exp_wa.size() == 0 &&
               !busy && !tx_valid && !rx_valid) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) fail({name, "_timeout"});
      @(posedge clk); #1;
   endtask

   // rx source: holds each byte until it is accepted.
   always @(negedge clk) begin
      if (rx_pend) begin
         void'(rxq.pop_front());
         rx_edge = cyc;
      end
      if (rxq.size() > 0 && !rst) begin
         rx_valid = 1'b1;
         rx_data  = rxq[0];
      end else begin
         rx_valid = 1'b0;
         rx_data  = 8'h00;
      end
      rx_pend = rx_valid && rx_ready;
   end

   // tx sink: always ready, or ready one cycle in three when stalling.
   always @(posedge clk) begin
      #1;
      tcnt++;
      tx_ready = stall_mode ? ((tcnt % 3) == 0) : 1'b1;
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (rst) begin
         chk("rx_ready_in_rst", rx_ready, 1'b0);
         stalled = 1'b0;
      end else begin
         if (bus_we) begin
            we_cyc = cyc;
            if (exp_wa.size() == 0) begin
               fail("unexpected_bus_we");
            end else begin
               chk("wr_addr", bus_addr, exp_wa.pop_front());
               chk("wr_data", bus_wdata, exp_wd.pop_front());
            end
         end
         if (stalled && tx_valid) chk("tx_hold", tx_data, held);
         if (tx_valid && tx_ready) begin
            tx_edge = cyc + 1;
            tx_log.push_back(tx_data);
            if (exp_tx.size() == 0) begin
               fail("unexpected_tx");
            end else begin
               chk("tx_data", tx_data, exp_tx.pop_front());
               if (exp_txc.pop_front()) chk("rd_addr", bus_addr, exp_txa.pop_front());
               else void'(exp_txa.pop_front());
            end
         end
         if (bus_we || tx_valid) chk("rx_ready_blocked", rx_ready, 1'b0);
         stalled = tx_valid && !tx_ready;
         held    = tx_data;
      end
   end

   task automatic chk_idle_regs(input string tag);
      @(negedge clk);
      chk({tag, "_bus_we"}, bus_we, 1'b0);
      chk({tag, "_tx_valid"}, tx_valid, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      errors = 0; checks = 0; cyc = 0; tcnt = 0; stall_mode = 1'b0; rx_pend = 1'b0;
      stalled = 1'b0; held = 8'h00; rx_edge = 0; we_cyc = -1; tx_edge = 0;
      for (int i = 0; i < 256; i++) begin
         mem[i]       = 8'(i) ^ 8'h5A;
         model_mem[i] = 8'(i) ^ 8'h5A;
      end
      mem[8'h10] = 8'h3C; model_mem[8'h10] = 8'h3C;
      mem[8'hFE] = 8'h11; model_mem[8'hFE] = 8'h11;
      mem[8'hFF] = 8'h22; model_mem[8'hFF] = 8'h22;
      mem[8'h00] = 8'h33; model_mem[8'h00] = 8'h33;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_idle_regs("reset");
      chk("reset_bus_addr", bus_addr, 8'h00);
      chk("reset_bus_wdata", bus_wdata, 8'h00);
      chk("reset_tx_data", tx_data, 8'h00);

      // Write 0F <- A5
      cmd(3, 8'h57, 8'h0F, 8'hA5);
      wait_done("write");
      chk("write_we_latency", we_cyc - rx_edge, 0);
      chk("write_ack_latency", tx_edge - rx_edge, 2);
      chk("write_mem", mem[8'h0F], 8'hA5);
      chk("write_ack_byte", tx_log[tx_log.size()-1], 8'h2B);

      // Single read
      cmd(2, 8'h52, 8'h10, 8'h00);
      wait_done("read");
      chk("read_latency", tx_edge - rx_edge, 2);
      chk("read_byte", tx_log[tx_log.size()-1], 8'h3C);

      // Burst with address wrap under backpressure
      stall_mode = 1'b1;
      cmd(3, 8'h42, 8'hFE, 8'h03);
      wait_done("burst");
      stall_mode = 1'b0;
      chk("burst_b0", tx_log[tx_log.size()-3], 8'h11);
      chk("burst_b1", tx_log[tx_log.size()-2], 8'h22);
      chk("burst_b2", tx_log[tx_log.size()-1], 8'h33);
      chk("burst_end_addr", bus_addr, 8'h00);

      // Unknown opcode and zero-count burst
      cmd(1, 8'h7A, 8'h00, 8'h00);
      wait_done("bad_op");
      chk("bad_op_byte", tx_log[tx_log.size()-1], 8'h3F);
      cmd(3, 8'h42, 8'h20, 8'h00);
      wait_done("zero_cnt");
      chk("zero_cnt_byte", tx_log[tx_log.size()-1], 8'h3F);

      // Reset in the middle of a write command
      rxq.push_back(8'h57);
      rxq.push_back(8'h0F);
      for (int k = 0; k < 50 && (rxq.size() != 0 || rx_pend); k++) @(negedge clk);
      if (rxq.size() != 0) fail("midrst_feed_timeout");
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk_idle_regs("midrst");
      cmd(2, 8'h52, 8'h0F, 8'h00);
      wait_done("midrst_read");
      chk("midrst_read_byte", tx_log[tx_log.size()-1], 8'hA5);

      // Back-to-back commands with rx_valid held high
      cmd(3, 8'h57, 8'h01, 8'hAA);
      cmd(2, 8'h52, 8'h01, 8'h00);
      wait_done("b2b");
      chk("b2b_ack", tx_log[tx_log.size()-2], 8'h2B);
      chk("b2b_read", tx_log[tx_log.size()-1], 8'hAA);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
